bcd2bin_rr_arbiter: RTL and testbench
=====================================

// Module: bcd2bin_rr_arbiter
// PURPOSE
//  Shares one 2-digit BCD-to-binary converter between N_REQ requesters, using round-robin arbitration.
//  Sequences the converter's start / ready / done_tick handshake for the selected requester.
//  Returns the result to that requester with a one-cycle ack pulse.
//  Digits are validated before launch. A watchdog aborts a stalled conversion.
//  Sits between the keypad/UART parsing clients and the single shared converter instance.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  TIMEOUT  15  max cycles in WAIT before abort (must be >= 10)
// PORTS
//  clk             in   1         system clock, all logic on rising edge
//  reset           in   1         synchronous, active-high
//  req             in   N_REQ     level request per client; hold until own ack
//  bcd1_in         in   4*N_REQ   tens digit, client i at [4i+3:4i]
//  bcd0_in         in   4*N_REQ   units digit, client i at [4i+3:4i]
//  ack             out  N_REQ     one-hot, 1-cycle pulse: result for client i valid
//  err             out  1         qualifies ack: 1 = bad digit or timeout
//  result          out  7         binary result, valid with ack (0 when err)
//  busy            out  1         high in any state except IDLE
//  conv_start      out  1         start pulse to converter
//  conv_bcd1       out  4         tens digit to converter (registered)
//  conv_bcd0       out  4         units digit to converter (registered)
//  conv_ready      in   1         converter idle / ready
//  conv_done_tick  in   1         converter finished; conv_bin valid this cycle
//  conv_bin        in   7         converter result
// BEHAVIOUR
//  Reset values
//   - All outputs 0, state = IDLE.
//   - Round-robin pointer last = N_REQ-1, so client 0 has first priority.
//   - A reset mid-conversion abandons it: no ack is issued.
//  Arbitration (IDLE)
//   - Taken when |req && conv_ready.
//   - Winner = first asserted req scanning last+1, last+2, ... with wrap modulo N_REQ.
//   - At that edge: latch winner index and its digits into conv_bcd1/conv_bcd0; last <= winner.
//   - If either latched digit > 9, go to FAIL; otherwise go to START.
//  States
//   - START: conv_start = 1 for exactly this cycle; clear watchdog count; go to WAIT.
//   - WAIT: count++ each cycle.
//     - On conv_done_tick: result <= conv_bin, go to ACK.
//     - Else, when count == TIMEOUT-1: go to FAIL.
//     - A conv_done_tick on the same cycle as the timeout wins (go to ACK).
//   - ACK: ack[winner] = 1 and err = 0 for one cycle; go to IDLE.
//   - FAIL: ack[winner] = 1, err = 1, result = 0 for one cycle; go to IDLE.
//  Outputs and timing
//   - ack, err and result are registered. result holds its value until the next ACK/FAIL.
//   - conv_done_tick outside WAIT is ignored.
//   - conv_bcd1/conv_bcd0 are stable from START through WAIT.
//   - Latency from req to ack = converter latency + 3 cycles (IDLE, START, ACK).
//   - Back-to-back service: IDLE is re-entered after ACK, so there is 1 idle cycle minimum between grants.
//  Requester rules
//   - A req dropped while being served does not cancel the conversion: ack is still pulsed.
//   - A req rising mid-service is queued by level and served in a later round.
//   - No client is granted twice while another client holds req continuously (fairness).
//   - conv_ready low in IDLE: stay in IDLE, no grant.
// TESTING
//  1. Single client: req[0]=1, bcd1=4, bcd0=2 -> conv_start once; ack=0001, result=42, err=0.
//  2. All 4 req held high -> grants in order 0,1,2,3,0; each ack one-hot, one per service.
//  3. Client 2 with bcd0=4'hA -> no conv_start; ack=0100, err=1, result=0 within 3 cycles.
//  4. Stub converter never asserts done_tick -> ack+err exactly TIMEOUT cycles after WAIT entry.
//  5. Reset asserted during WAIT -> next cycle busy=0, ack=0; a new req then completes normally.
//  6. Sweep 00..99 on client 1 -> result equals 10*bcd1+bcd0 for every pair.

Source files
------------

// File: rtl/bcd2bin_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bcd2bin_rr_arbiter
//   Shares a single 2-digit BCD-to-binary converter between N_REQ clients.
//   A round-robin arbiter picks one requesting client, the digits are checked,
//   the converter start/ready/done handshake is sequenced, and the result is
//   returned to the winner with a one-cycle one-hot ack. A watchdog aborts a
//   conversion that does not finish within TIMEOUT cycles of entering WAIT.
//
// Ports
//   i_clk            system clock, all logic on rising edge
//   i_reset          synchronous, active-high reset
//   i_req            level request per client, held until own ack
//   i_bcd1_in        tens digits, client i at [4i+3:4i]
//   i_bcd0_in        units digits, client i at [4i+3:4i]
//   o_ack            one-hot, one-cycle pulse: result for client i valid
//   o_err            qualifies o_ack: bad digit or watchdog timeout
//   o_result         binary result valid with o_ack (0 on error), held otherwise
//   o_busy           high in every state except IDLE
//   o_conv_start     one-cycle start pulse to the converter
//   o_conv_bcd1      tens digit to converter (registered)
//   o_conv_bcd0      units digit to converter (registered)
//   i_conv_ready     converter idle / ready
//   i_conv_done_tick converter finished, i_conv_bin valid this cycle
//   i_conv_bin       converter result
// -----------------------------------------------------------------------------
module bcd2bin_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [4*N_REQ-1:0] i_bcd1_in,
    input  logic [4*N_REQ-1:0] i_bcd0_in,
    output logic [N_REQ-1:0]   o_ack,
    output logic               o_err,
    output logic [6:0]         o_result,
    output logic               o_busy,
    output logic               o_conv_start,
    output logic [3:0]         o_conv_bcd1,
    output logic [3:0]         o_conv_bcd0,
    input  logic               i_conv_ready,
    input  logic               i_conv_done_tick,
    input  logic [6:0]         i_conv_bin
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    // A BCD digit is legal only in the range 0..9.
    function automatic logic digit_ok(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    // One-hot vector with a single bit set at position idx.
    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IW-1:0]    r_last;
    logic [IW-1:0]    r_winner;
    logic [CW-1:0]    r_count;
    logic [N_REQ-1:0] r_ack;
    logic             r_err;
    logic [6:0]       r_result;
    logic             r_busy;
    logic             r_conv_start;
    logic [3:0]       r_conv_bcd1;
    logic [3:0]       r_conv_bcd0;

    logic             w_found;
    logic             w_hit;
    logic [IW-1:0]    w_scan;
    logic [IW-1:0]    w_grant_idx;
    logic [3:0]       w_cand_bcd1;
    logic [3:0]       w_cand_bcd0;
    logic             w_grant;
    logic [IW-1:0]    w_fail_idx;

    // Round-robin scan: first asserted request starting just after r_last.
    always_comb begin
        w_found     = 1'b0;
        w_hit       = 1'b0;
        w_scan      = '0;
        w_grant_idx = r_last;
        for (int k = 1; k <= N_REQ; k++) begin
            // Wrap without a modulo so non-power-of-two N_REQ works.
            w_scan      = (int'(r_last) + k >= N_REQ) ? IW'(int'(r_last) + k - N_REQ)
                                                      : IW'(int'(r_last) + k);
            w_hit       = !w_found && i_req[w_scan];
            w_grant_idx = w_hit ? w_scan : w_grant_idx;
            w_found     = w_found | w_hit;
        end
    end

    // Digits of the candidate winner, checked before any launch.
    always_comb begin
        w_cand_bcd1 = i_bcd1_in[4*w_grant_idx +: 4];
        w_cand_bcd0 = i_bcd0_in[4*w_grant_idx +: 4];
    end

    // Next-state logic of the service sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && i_conv_ready) begin
                    w_grant     = 1'b1;
                    w_state_nxt = (digit_ok(w_cand_bcd1) && digit_ok(w_cand_bcd0)) ? S_START : S_FAIL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // A done tick on the timeout cycle still wins.
                if (i_conv_done_tick) begin
                    w_state_nxt = S_ACK;
                end else if (r_count == CNT_LAST) begin
                    w_state_nxt = S_FAIL;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            S_FAIL:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A FAIL straight out of IDLE has no latched winner yet.
    always_comb begin
        w_fail_idx = (r_state == S_IDLE) ? w_grant_idx : r_winner;
    end

    // State register, arbitration pointer, watchdog and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_last       <= LAST_RST;
            r_winner     <= '0;
            r_count      <= '0;
            r_ack        <= '0;
            r_err        <= 1'b0;
            r_result     <= 7'd0;
            r_busy       <= 1'b0;
            r_conv_start <= 1'b0;
            r_conv_bcd1  <= 4'd0;
            r_conv_bcd0  <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_conv_start <= (w_state_nxt == S_START);

            if (w_grant) begin
                r_winner    <= w_grant_idx;
                r_last      <= w_grant_idx;
                r_conv_bcd1 <= w_cand_bcd1;
                r_conv_bcd0 <= w_cand_bcd0;
            end

            if (r_state == S_START) begin
                r_count <= '0;
            end else if (r_state == S_WAIT) begin
                r_count <= r_count + 1'b1;
            end

            // ack/err pulse for one cycle; result holds between services.
            r_ack <= '0;
            r_err <= 1'b0;
            if (w_state_nxt == S_ACK) begin
                r_ack    <= onehot(r_winner);
                r_result <= i_conv_bin;
            end else if (w_state_nxt == S_FAIL) begin
                r_ack    <= onehot(w_fail_idx);
                r_err    <= 1'b1;
                r_result <= 7'd0;
            end
        end
    end

    assign o_ack        = r_ack;
    assign o_err        = r_err;
    assign o_result     = r_result;
    assign o_busy       = r_busy;
    assign o_conv_start = r_conv_start;
    assign o_conv_bcd1  = r_conv_bcd1;
    assign o_conv_bcd0  = r_conv_bcd0;

endmodule

// File: tb/tb_bcd2bin_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bcd2bin_rr_arbiter
//   Scoreboard bench for bcd2bin_rr_arbiter. Rounds of requests are issued; a
//   reference model predicts the round-robin service order and the response of
//   each service (value, bad digit, watchdog) and queues it. A monitor pops and
//   compares whenever the DUT pulses ack. A behavioural converter stub answers
//   conv_start with a per-service latency chosen by the stimulus.
// -----------------------------------------------------------------------------
module tb_bcd2bin_rr_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;

    typedef struct {
        int cl;    // client index
        int kind;  // 0 = good, 1 = bad digit, 2 = watchdog timeout
        int res;   // expected result value
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [4*N-1:0] bcd1;
    logic [4*N-1:0] bcd0;
    logic [N-1:0]   ack;
    logic           err;
    logic [6:0]     result;
    logic           busy;
    logic           conv_start;
    logic [3:0]     conv_bcd1;
    logic [3:0]     conv_bcd0;
    logic           conv_ready;
    logic           done;
    logic [6:0]     bin;

    exp_t       exp_q[$];
    int         lat_q[$];
    int         n_cmp      = 0;
    int         n_bad      = 0;
    int         m_last     = N - 1;
    int         n_start    = 0;
    int         start_cyc  = -100;
    int         done_cyc   = -100;
    int         ack_cyc    = -100;
    int         req_cyc    = 0;
    int         cyc        = 0;
    bit         ready_rand = 1'b1;
    logic [3:0] d1 [N];
    logic [3:0] d0 [N];
    int         lat [N];

    bcd2bin_rr_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_req           (req),
        .i_bcd1_in       (bcd1),
        .i_bcd0_in       (bcd0),
        .o_ack           (ack),
        .o_err           (err),
        .o_result        (result),
        .o_busy          (busy),
        .o_conv_start    (conv_start),
        .o_conv_bcd1     (conv_bcd1),
        .o_conv_bcd0     (conv_bcd0),
        .i_conv_ready    (conv_ready),
        .i_conv_done_tick(done),
        .i_conv_bin      (bin)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Behavioural converter: latency taken from lat_q, 0 means it never finishes.
    initial begin : conv_stub
        int         cnt;
        bit         pend;
        bit         silent;
        logic [3:0] c1;
        logic [3:0] c0;
        pend = 1'b0; silent = 1'b0; cnt = 0; c1 = 4'd0; c0 = 4'd0;
        done = 1'b0; bin = 7'd0; conv_ready = 1'b1;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else if (conv_start) begin
                pend      = 1'b1;
                c1        = conv_bcd1;
                c0        = conv_bcd0;
                n_start++;
                start_cyc = cyc;
                cnt       = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                silent    = (cnt == 0);
                if (silent) cnt = TO + 2;
            end else if (pend) begin
                check("conv_digits_stable", {24'd0, conv_bcd1, conv_bcd0}, {24'd0, c1, c0});
                cnt--;
                if (cnt == 0) begin
                    pend = 1'b0;
                    if (!silent) begin
                        done     = 1'b1;
                        bin      = 7'(10 * c1 + c0);
                        done_cyc = cyc;
                    end
                end
            end
            conv_ready = !pend && (!ready_rand || ($urandom_range(0, 5) != 0));
        end
    end

    // Monitor: every ack pulse is matched against the head of the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (ack != '0 || err)) begin
                ack_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack: ack=%b err=%b with nothing expected", ack, err);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_onehot_client", int'(ack), 1 << e.cl);
                    check("err_flag", int'(err), int'(e.kind != 0));
                    check("result", int'(result), e.res);
                    if (e.kind == 0) begin
                        check("ack_cycles_after_done", cyc - done_cyc, 1);
                    end else if (e.kind == 2) begin
                        check("timeout_cycles_after_wait_entry", cyc - (start_cyc + 1), TO);
                    end
                end
            end
        end
    end

    // Model a round: all clients in 'set' raise req together and hold it until acked.
    task automatic run_round(input logic [N-1:0] set);
        int   order[$];
        int   c;
        int   budget;
        exp_t e;
        for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (set[c]) order.push_back(c);
        end
        foreach (order[j]) begin
            c    = order[j];
            e.cl = c;
            if (d1[c] > 4'd9 || d0[c] > 4'd9) begin
                e.kind = 1; e.res = 0;
            end else begin
                lat_q.push_back(lat[c]);
                if (lat[c] == 0 || lat[c] > TO) begin
                    e.kind = 2; e.res = 0;
                end else begin
                    e.kind = 0; e.res = 10 * d1[c] + d0[c];
                end
            end
            exp_q.push_back(e);
        end
        if (order.size() > 0) m_last = order[order.size() - 1];
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            bcd1[4*i +: 4] = d1[i];
            bcd0[4*i +: 4] = d0[i];
        end
        req     = set;
        req_cyc = cyc;
        budget  = 0;
        while (req != '0 && budget < 400) begin
            @(negedge clk);
            budget++;
            req = req & ~ack;
        end
        if (req != '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL round_budget: req=%b never acked", req);
            req = '0;
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
        lat_q.delete();
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = conv_start;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL conv_start_wait: conv_start=%b never seen", conv_start);
        end
    endtask

    initial begin : stimulus
        int   n0;
        int   r;
        bit   ok;
        exp_t e;
        reset = 1'b1; req = '0; bcd1 = '0; bcd0 = '0;
        for (int i = 0; i < N; i++) begin d1[i] = 4'd0; d0[i] = 4'd0; lat[i] = 1; end
        repeat (3) @(negedge clk);
        check("rst_ack", int'(ack), 0);
        check("rst_err", int'(err), 0);
        check("rst_result", int'(result), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_conv_start", int'(conv_start), 0);
        check("rst_conv_bcd1", int'(conv_bcd1), 0);
        check("rst_conv_bcd0", int'(conv_bcd0), 0);
        reset = 1'b0;
        @(negedge clk);

        // All four held: 0,1,2,3 then 0,1,2,3 again.
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int i = 0; i < N; i++) begin
                d1[i] = 4'($urandom_range(0, 9));
                d0[i] = 4'($urandom_range(0, 9));
                lat[i] = $urandom_range(1, 5);
            end
            run_round(4'hF);
        end

        // Single client 42.
        d1[0] = 4'd4; d0[0] = 4'd2; lat[0] = 3;
        n0 = n_start;
        run_round(4'b0001);
        check("single_start_count", n_start - n0, 1);

        // Bad digit on client 2: no launch, fast error ack.
        ready_rand = 1'b0;
        d1[2] = 4'd3; d0[2] = 4'hA;
        n0 = n_start;
        run_round(4'b0100);
        check("bad_digit_no_start", n_start - n0, 0);
        check("bad_digit_ack_within_3", int'(ack_cyc - req_cyc <= 3), 1);

        // Converter hangs: watchdog abort, then the boundary latencies TO and TO+1.
        d1[1] = 4'd7; d0[1] = 4'd1; lat[1] = 0;
        run_round(4'b0010);
        lat[1] = TO;
        run_round(4'b0010);
        lat[1] = TO + 1;
        run_round(4'b0010);

        // Req dropped while being served still gets its ack.
        e.cl = 3; e.kind = 0; e.res = 99;
        exp_q.push_back(e);
        lat_q.push_back(6);
        m_last = 3;
        @(negedge clk);
        bcd1[15:12] = 4'd9; bcd0[15:12] = 4'd9;
        req = 4'b1000;
        wait_start(ok);
        req = '0;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) @(negedge clk);
        check("dropped_req_acked", exp_q.size(), 0);
        exp_q.delete();
        lat_q.delete();
        repeat (2) @(negedge clk);

        // Reset during WAIT abandons the service and restores the pointer.
        bcd1[3:0] = 4'd5; bcd0[3:0] = 4'd5;
        lat_q.push_back(0);
        req = 4'b0001;
        wait_start(ok);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        check("reset_mid_wait_busy", int'(busy), 0);
        check("reset_mid_wait_ack", int'(ack), 0);
        @(negedge clk);
        reset  = 1'b0;
        m_last = N - 1;
        lat_q.delete();
        d1[0] = 4'd1; d0[0] = 4'd8; lat[0] = 2;
        d1[3] = 4'd6; d0[3] = 4'd3; lat[3] = 4;
        run_round(4'b1001);
        ready_rand = 1'b1;

        // Sweep every legal pair on client 1.
        for (int t = 0; t < 10; t++) begin
            for (int u = 0; u < 10; u++) begin
                d1[1] = 4'(t); d0[1] = 4'(u); lat[1] = $urandom_range(1, 4);
                run_round(4'b0010);
            end
        end

        // Random rounds mixing bad digits, hangs and boundary latencies.
        for (int rnd = 0; rnd < 40; rnd++) begin
            for (int i = 0; i < N; i++) begin
                d1[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                d0[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                r = $urandom_range(0, 9);
                lat[i] = (r == 0) ? 0 : (r == 1) ? TO : (r == 2) ? TO + 1 : $urandom_range(1, 6);
            end
            run_round(4'($urandom_range(1, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
